// File: rtl/ps2_scancode_fifo_pkg.sv
// Shared register addresses, entry layout and KBSTATUS bit map for the PS/2 scancode queue.
// Software headers and ps2_keyb-level logic take their bit positions from here.
package ps2_scancode_fifo_pkg;

    localparam logic [7:0] SCANCODE = 8'h04;
    localparam logic [7:0] KBSTATUS = 8'h05;

    localparam int ENTRY_W   = 10;
    localparam int ENT_EXT   = 9;
    localparam int ENT_REL   = 8;
    localparam int ENT_CODE  = 0;

    localparam int KBS_BUSY  = 7;
    localparam int KBS_OVF   = 6;
    localparam int KBS_ERR   = 3;
    localparam int KBS_REL   = 2;
    localparam int KBS_EXT   = 1;
    localparam int KBS_NE    = 0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } scan_entry_t;

    // Head flags are masked when the queue is empty so stale RAM never leaks out.
    function automatic logic [7:0] kbstatus_byte(
        input logic        busy,
        input logic        ovf,
        input logic        err,
        input scan_entry_t head,
        input logic        not_empty
    );
        logic [7:0] s;
        s           = 8'h00;
        s[KBS_BUSY] = busy;
        s[KBS_OVF]  = ovf;
        s[KBS_ERR]  = err;
        s[KBS_REL]  = head.rel & not_empty;
        s[KBS_EXT]  = head.ext & not_empty;
        s[KBS_NE]   = not_empty;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; the head entry is always presented on dout.
// Shared by the keyboard and mouse paths.
module sync_fifo_fwft #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    // Full/empty come from the counter so pointers can wrap freely.
    always_comb begin
        do_pop  = pop && (level_q != '0);
        do_push = push && ((level_q != LW'(DEPTH)) || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

    assign dout  = mem[rd_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/ps2_scancode_fifo.sv
// Queues decoded PS/2 scancode events for the CPU; each completed SCANCODE read pops one entry.
// Holds the typematic-repeat filter, read-edge detectors, sticky overflow and the status byte.
module ps2_scancode_fifo
    import ps2_scancode_fifo_pkg::*;
#(
    parameter int         DEPTH         = 16,
    parameter logic [7:0] SCANCODE_ADDR = SCANCODE,
    parameter logic [7:0] KBSTATUS_ADDR = KBSTATUS,
    parameter int         FILTER_REPEAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_received,
    input  logic [7:0]             scancode,
    input  logic                   extended,
    input  logic                   released,
    input  logic                   ps2busy,
    input  logic                   kberror,
    input  logic [7:0]             zxuno_addr,
    input  logic                   zxuno_regrd,
    output logic [7:0]             scancode_dout,
    output logic                   oe_scancode,
    output logic [7:0]             kbstatus_dout,
    output logic                   oe_kbstatus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   kb_irq
);

    localparam bit FILT = (FILTER_REPEAT != 0);

    logic                   oe_sc_q, oe_ks_q;
    logic                   ovf_q, ovf_d;
    logic                   lm_valid_q, lm_valid_d;
    logic                   lm_ext_q, lm_ext_d;
    logic [7:0]             lm_code_q, lm_code_d;
    logic                   busy_q, err_q;

    logic                   pop_edge, ks_edge;
    logic                   lm_match, drop_rep, push, ovf_event;
    logic [ENTRY_W-1:0]     fifo_din, fifo_dout;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   fifo_full, fifo_empty;
    scan_entry_t            head;

    assign oe_scancode = (zxuno_addr == SCANCODE_ADDR) && zxuno_regrd;
    assign oe_kbstatus = (zxuno_addr == KBSTATUS_ADDR) && zxuno_regrd;

    always_comb begin
        pop_edge   = oe_sc_q && !oe_scancode;
        ks_edge    = oe_ks_q && !oe_kbstatus;
        lm_match   = lm_valid_q && (lm_ext_q == extended) && (lm_code_q == scancode);
        drop_rep   = FILT && scan_received && !released && lm_match;
        push       = scan_received && !drop_rep;
        // A pop in the same cycle frees the slot, so only a pop-less full push overflows.
        ovf_event  = push && fifo_full && !pop_edge;

        ovf_d = ovf_q;
        if (ks_edge)   ovf_d = 1'b0;
        if (ovf_event) ovf_d = 1'b1;

        lm_valid_d = lm_valid_q;
        lm_ext_d   = lm_ext_q;
        lm_code_d  = lm_code_q;
        if (FILT && scan_received) begin
            if (!released && !lm_match) begin
                lm_valid_d = 1'b1;
                lm_ext_d   = extended;
                lm_code_d  = scancode;
            end else if (released && lm_match) begin
                lm_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_sc_q    <= 1'b0;
            oe_ks_q    <= 1'b0;
            ovf_q      <= 1'b0;
            lm_valid_q <= 1'b0;
        end else begin
            oe_sc_q    <= oe_scancode;
            oe_ks_q    <= oe_kbstatus;
            ovf_q      <= ovf_d;
            lm_valid_q <= lm_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        lm_ext_q  <= lm_ext_d;
        lm_code_q <= lm_code_d;
        busy_q    <= ps2busy;
        err_q     <= kberror;
    end

    assign fifo_din = {extended, released, scancode};

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop_edge),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head          = scan_entry_t'(fifo_dout);
    assign scancode_dout = fifo_empty ? 8'h00 : head.code;
    assign kbstatus_dout = kbstatus_byte(busy_q, ovf_q, err_q, head, !fifo_empty);
    assign level         = fifo_level;
    assign kb_irq        = !fifo_empty;

endmodule
